// File: rtl/text_console_if.sv
// text_console_if
//   Groups the byte-stream handshake and the tram write port of the text
//   console into one bundle.
//   Byte stream : in_data, in_valid, in_ready, colr_fg, colr_bg
//   Tram port   : tram_we, tram_addr, tram_din
//   Status      : scroll_offs, cur_x, cur_y, busy
//   Modports    : master = byte producer / status observer,
//                 slave  = the console itself.
interface text_console_if #(
  parameter int ADDRW    = 11,
  parameter int WORD     = 32,
  parameter int BYTE_CNT = 4,
  parameter int CIDXW    = 4
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [CIDXW-1:0]    colr_fg;
  logic [CIDXW-1:0]    colr_bg;
  logic [BYTE_CNT-1:0] tram_we;
  logic [ADDRW-1:0]    tram_addr;
  logic [WORD-1:0]     tram_din;
  logic [ADDRW-1:0]    scroll_offs;
  logic [6:0]          cur_x;
  logic [4:0]          cur_y;
  logic                busy;

  modport master (
    output in_data, in_valid, colr_fg, colr_bg,
    input  in_ready, tram_we, tram_addr, tram_din, scroll_offs, cur_x, cur_y, busy
  );

  modport slave (
    input  in_data, in_valid, colr_fg, colr_bg,
    output in_ready, tram_we, tram_addr, tram_din, scroll_offs, cur_x, cur_y, busy
  );
endinterface

// File: rtl/text_console.sv
// text_console
//   Character-stream writer for the text mode RAM. Accepts one byte per
//   handshake, writes one glyph word per printable character, keeps the
//   cursor, wraps lines and scrolls by advancing the ring-buffer start
//   offset read by the display side.
//   clk_sys  : system clock
//   rst_sys  : asynchronous active-low reset
//   bus      : slave side of text_console_if (byte stream in, tram writes,
//              scroll offset, cursor and busy out)
module text_console #(
  parameter int          ADDRW     = 11,
  parameter int          WORD      = 32,
  parameter int          BYTE_CNT  = 4,
  parameter int          CIDXW     = 4,
  parameter int          TRAM_HRES = 84,
  parameter int          TRAM_VRES = 24,
  parameter logic [7:0]  SPACE     = 8'h20
) (
  input  logic           clk_sys,
  input  logic           rst_sys,
  text_console_if.slave  bus
);

  localparam int SIZE = TRAM_HRES * TRAM_VRES;

  typedef enum logic [2:0] {IDLE, PUT, NEWLINE, CLRLINE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [6:0]       cur_x_q, cur_x_d;
  logic [4:0]       cur_y_q, cur_y_d;
  logic [ADDRW-1:0] scroll_q, scroll_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;
  logic [7:0]       char_q, char_d;
  logic [CIDXW-1:0] fg_q, fg_d;
  logic [CIDXW-1:0] bg_q, bg_d;

  logic                inReady;
  logic                accept;
  logic [ADDRW:0]      rowOffs;
  logic [ADDRW:0]      colTerm;
  logic [ADDRW:0]      rawAddr;
  logic [ADDRW:0]      wrapAddr;
  logic [ADDRW:0]      scrollSum;
  logic [ADDRW-1:0]    nextScroll;
  logic [WORD-1:0]     putWord;
  logic [WORD-1:0]     spaceWord;
  logic [BYTE_CNT-1:0] weC;
  logic [ADDRW-1:0]    addrC;
  logic [WORD-1:0]     dinC;
  logic                busyC;

  // Gating with rst_sys keeps in_ready low for the whole reset assertion.
  assign inReady = (state_q == IDLE) && rst_sys;
  assign accept  = inReady && bus.in_valid;

  // Ring-buffer address of the cursor cell (or of the CLRLINE column).
  // The sum stays below 2*SIZE, so a single compare-and-subtract wraps it.
  assign rowOffs  = (ADDRW+1)'(cur_y_q) * (ADDRW+1)'(TRAM_HRES);
  assign colTerm  = (state_q == CLRLINE) ? (ADDRW+1)'(cnt_q) : (ADDRW+1)'(cur_x_q);
  assign rawAddr  = {1'b0, scroll_q} + rowOffs + colTerm;
  assign wrapAddr = (rawAddr >= (ADDRW+1)'(SIZE)) ? rawAddr - (ADDRW+1)'(SIZE) : rawAddr;

  assign scrollSum  = {1'b0, scroll_q} + (ADDRW+1)'(TRAM_HRES);
  assign nextScroll = (scrollSum >= (ADDRW+1)'(SIZE)) ?
                      ADDRW'(scrollSum - (ADDRW+1)'(SIZE)) : ADDRW'(scrollSum);

  assign putWord   = {{(WORD-8-2*CIDXW){1'b0}}, bg_q, fg_q, char_q};
  assign spaceWord = {{(WORD-8-2*CIDXW){1'b0}}, bg_q, fg_q, SPACE};

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q  <= IDLE;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      scroll_q <= '0;
      cnt_q    <= '0;
      char_q   <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      scroll_q <= scroll_d;
      cnt_q    <= cnt_d;
      char_q   <= char_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    scroll_d = scroll_q;
    cnt_d    = cnt_q;
    char_d   = char_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    weC      = '0;
    addrC    = '0;
    dinC     = '0;
    busyC    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Colours are captured on every accept so that a later CLRLINE
          // uses the colours of the byte that caused the scroll.
          char_d = bus.in_data;
          fg_d   = bus.colr_fg;
          bg_d   = bus.colr_bg;
          if (bus.in_data >= 8'h20) begin
            state_d = PUT;
          end else begin
            case (bus.in_data)
              8'h0A: begin
                cur_x_d = '0;
                state_d = NEWLINE;
              end
              8'h0D: cur_x_d = '0;
              8'h08: if (cur_x_q != 7'd0) cur_x_d = cur_x_q - 7'd1;
              8'h0C: begin
                scroll_d = '0;
                cur_x_d  = '0;
                cur_y_d  = '0;
                cnt_d    = '0;
                state_d  = CLEAR;
              end
              default: ;
            endcase
          end
        end
      end

      PUT: begin
        weC   = '1;
        addrC = wrapAddr[ADDRW-1:0];
        dinC  = putWord;
        if (cur_x_q == 7'(TRAM_HRES-1)) begin
          cur_x_d = '0;
          state_d = NEWLINE;
        end else begin
          cur_x_d = cur_x_q + 7'd1;
          state_d = IDLE;
        end
      end

      NEWLINE: begin
        if (cur_y_q < 5'(TRAM_VRES-1)) begin
          cur_y_d = cur_y_q + 5'd1;
          state_d = IDLE;
        end else begin
          scroll_d = nextScroll;
          cnt_d    = '0;
          state_d  = CLRLINE;
        end
      end

      CLRLINE: begin
        // cur_y is pinned at the bottom row here, so wrapAddr walks that row.
        busyC = 1'b1;
        weC   = '1;
        addrC = wrapAddr[ADDRW-1:0];
        dinC  = spaceWord;
        if (cnt_q == ADDRW'(TRAM_HRES-1)) state_d = IDLE;
        else                               cnt_d   = cnt_q + 1'b1;
      end

      CLEAR: begin
        busyC = 1'b1;
        weC   = '1;
        addrC = cnt_q;
        dinC  = spaceWord;
        if (cnt_q == ADDRW'(SIZE-1)) state_d = IDLE;
        else                          cnt_d   = cnt_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = inReady;
  assign bus.tram_we     = weC;
  assign bus.tram_addr   = addrC;
  assign bus.tram_din    = dinC;
  assign bus.scroll_offs = scroll_q;
  assign bus.cur_x       = cur_x_q;
  assign bus.cur_y       = cur_y_q;
  assign bus.busy        = busyC;

endmodule

// File: tb/tb_text_console.sv
// tb_text_console
//   Randomised self-checking bench for text_console. A reference model
//   (cursor, scroll offset and ring-buffer arithmetic) queues the expected
//   tram writes; a monitor pops one entry per observed write.
module tb_text_console;

  localparam int HRES = 84;
  localparam int VRES = 24;
  localparam int SIZE = HRES * VRES;

  logic clk_sys = 1'b0;
  logic rst_sys;

  text_console_if bus();

  text_console dut (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          addr;
    logic [31:0] din;
    logic        busy;
  } wr_t;

  wr_t         expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          writeCount = 0;
  int          lastAddr = 0;
  logic [31:0] lastDin = '0;
  int          mX = 0;
  int          mY = 0;
  int          mScroll = 0;

  function automatic logic [31:0] mkWord(input logic [7:0] g, input logic [3:0] fg, input logic [3:0] bg);
    return {16'h0000, bg, fg, g};
  endfunction

  task automatic pushWrite(input int addr, input logic [31:0] din, input logic busyExp);
    wr_t e;
    e.addr = addr;
    e.din  = din;
    e.busy = busyExp;
    expQ.push_back(e);
  endtask

  task automatic modelNewline(input logic [3:0] fg, input logic [3:0] bg);
    if (mY < VRES - 1) begin
      mY++;
    end else begin
      mScroll = (mScroll + HRES) % SIZE;
      for (int c = 0; c < HRES; c++)
        pushWrite((mScroll + (VRES - 1) * HRES + c) % SIZE, mkWord(8'h20, fg, bg), 1'b1);
    end
  endtask

  task automatic modelByte(input logic [7:0] b, input logic [3:0] fg, input logic [3:0] bg);
    if (b >= 8'h20) begin
      pushWrite((mScroll + mY * HRES + mX) % SIZE, mkWord(b, fg, bg), 1'b0);
      mX++;
      if (mX == HRES) begin
        mX = 0;
        modelNewline(fg, bg);
      end
    end else if (b == 8'h0A) begin
      mX = 0;
      modelNewline(fg, bg);
    end else if (b == 8'h0D) begin
      mX = 0;
    end else if (b == 8'h08) begin
      if (mX > 0) mX--;
    end else if (b == 8'h0C) begin
      mScroll = 0;
      mX = 0;
      mY = 0;
      for (int a = 0; a < SIZE; a++) pushWrite(a, mkWord(8'h20, fg, bg), 1'b1);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Presents one byte when the console is ready; the model is updated at
  // the moment the byte is actually handed over.
  task automatic applyStimulus(input logic [7:0] b, input logic [3:0] fg, input logic [3:0] bg);
    int guard = 0;
    @(negedge clk_sys);
    while (bus.in_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk_sys);
      guard++;
    end
    if (bus.in_ready !== 1'b1) begin
      checkOutput("readyTimeout", 32'(bus.in_ready), 32'd1);
    end else begin
      modelByte(b, fg, bg);
      bus.in_data  = b;
      bus.colr_fg  = fg;
      bus.colr_bg  = bg;
      bus.in_valid = 1'b1;
      @(posedge clk_sys);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int guard = 0;
    @(negedge clk_sys);
    while (bus.in_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk_sys);
      guard++;
    end
    checkOutput("idleReached", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic checkState();
    checkOutput("curX", 32'(bus.cur_x), 32'(mX));
    checkOutput("curY", 32'(bus.cur_y), 32'(mY));
    checkOutput("scrollOffs", 32'(bus.scroll_offs), 32'(mScroll));
    checkOutput("pendingWrites", 32'(expQ.size()), 32'd0);
  endtask

  task automatic measureBusy(input string name, input int exp);
    int guard = 0;
    int n = 0;
    @(negedge clk_sys);
    while (bus.busy !== 1'b1 && guard < 10) begin
      @(negedge clk_sys);
      guard++;
    end
    while (bus.busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk_sys);
    end
    checkOutput(name, 32'(n), 32'(exp));
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstTramWe", 32'(bus.tram_we), 32'd0);
    checkOutput("rstTramAddr", 32'(bus.tram_addr), 32'd0);
    checkOutput("rstTramDin", bus.tram_din, 32'd0);
    checkOutput("rstScroll", 32'(bus.scroll_offs), 32'd0);
    checkOutput("rstCurX", 32'(bus.cur_x), 32'd0);
    checkOutput("rstCurY", 32'(bus.cur_y), 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd0);
  endtask

  function automatic logic [7:0] randPrintable();
    return 8'($urandom_range(32, 255));
  endfunction

  // Scoreboard monitor: every cycle with a tram write consumes one entry.
  always @(negedge clk_sys) begin
    if (rst_sys === 1'b1 && bus.tram_we !== 4'h0) begin
      writeCount++;
      lastAddr = int'(bus.tram_addr);
      lastDin  = bus.tram_din;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedWrite: got addr=%0d din=%h we=%h, want no write",
                 bus.tram_addr, bus.tram_din, bus.tram_we);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        if (bus.tram_we !== 4'hF || int'(bus.tram_addr) != e.addr ||
            bus.tram_din !== e.din || bus.busy !== e.busy) begin
          errors++;
          $display("[TB] FAIL tramWrite: got addr=%0d din=%h we=%h busy=%b, want addr=%0d din=%h we=f busy=%b",
                   bus.tram_addr, bus.tram_din, bus.tram_we, bus.busy, e.addr, e.din, e.busy);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int         baseCount;
    int         guard;
    int         r;

    rst_sys      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.colr_fg  = '0;
    bus.colr_bg  = '0;

    repeat (3) @(negedge clk_sys);
    checkResetOutputs();
    rst_sys = 1'b1;
    #1;
    checkOutput("readyAfterRelease", 32'(bus.in_ready), 32'd1);

    // First character and the one-cycle ready gap.
    applyStimulus(8'h41, 4'h7, 4'h1);
    @(negedge clk_sys);
    checkOutput("readyLowInPut", 32'(bus.in_ready), 32'd0);
    @(negedge clk_sys);
    checkOutput("readyBackInIdle", 32'(bus.in_ready), 32'd1);
    checkOutput("firstWordLiteral", lastDin, 32'h0000_1741);
    checkOutput("firstAddr", 32'(lastAddr), 32'd0);
    checkState();

    // Fill the rest of row 0; the wrap lands on row 1 without scrolling.
    for (int i = 1; i < HRES; i++)
      applyStimulus(randPrintable(), 4'($urandom), 4'($urandom));
    waitIdle();
    checkOutput("rowEndAddr", 32'(lastAddr), 32'd83);
    checkOutput("rowWrapY", 32'(bus.cur_y), 32'd1);
    checkState();

    // Walk down to the bottom row, then scroll once.
    while (mY < VRES - 1) applyStimulus(8'h0A, 4'($urandom), 4'($urandom));
    waitIdle();
    checkState();
    applyStimulus(8'h0A, 4'h3, 4'h9);
    measureBusy("scrollBusyLen", HRES);
    waitIdle();
    checkOutput("firstScroll", 32'(bus.scroll_offs), 32'd84);
    checkState();

    // A full lap of scrolls so the offset wraps back through zero.
    for (int k = 0; k < VRES; k++) begin
      r = $urandom_range(0, 3);
      for (int j = 0; j < r; j++) applyStimulus(randPrintable(), 4'($urandom), 4'($urandom));
      applyStimulus(8'h0A, 4'($urandom), 4'($urandom));
      measureBusy("lapScrollBusy", HRES);
      waitIdle();
      checkState();
    end

    // Backspace, carriage return and ignored control codes.
    applyStimulus(8'h0D, 4'h2, 4'h0);
    applyStimulus(8'h41, 4'h2, 4'h0);
    applyStimulus(8'h42, 4'h2, 4'h0);
    applyStimulus(8'h08, 4'h2, 4'h0);
    applyStimulus(8'h43, 4'h5, 4'h6);
    waitIdle();
    checkOutput("bsOverwriteCol", 32'(lastAddr), 32'((mScroll + (VRES - 1) * HRES + 1) % SIZE));
    checkState();
    applyStimulus(8'h0D, 4'h0, 4'h0);
    applyStimulus(8'h08, 4'h0, 4'h0);
    applyStimulus(8'h01, 4'h0, 4'h0);
    applyStimulus(8'h1B, 4'h0, 4'h0);
    applyStimulus(8'h09, 4'h0, 4'h0);
    waitIdle();
    checkState();

    // Random mix of printables and control codes.
    for (int i = 0; i < 240; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12 || r == 19) b = randPrintable();
      else if (r < 14)       b = 8'h0A;
      else if (r == 14)      b = 8'h0D;
      else if (r < 17)       b = 8'h08;
      else                   b = 8'($urandom_range(0, 31)) & 8'h13;
      applyStimulus(b, 4'($urandom), 4'($urandom));
      if (i % 10 == 9) begin
        waitIdle();
        checkState();
      end
    end
    waitIdle();
    checkState();

    // Full-screen clear.
    applyStimulus(8'h0C, 4'hA, 4'h4);
    measureBusy("clearBusyLen", SIZE);
    waitIdle();
    checkState();

    // Clear interrupted by reset after about 100 writes.
    applyStimulus(8'h58, 4'h1, 4'h2);
    applyStimulus(8'h0C, 4'hB, 4'hC);
    baseCount = writeCount;
    guard = 0;
    while (writeCount < baseCount + 100 && guard < 500) begin
      @(negedge clk_sys);
      guard++;
    end
    checkOutput("clearProgress", 32'(writeCount >= baseCount + 100), 32'd1);
    #2;
    rst_sys = 1'b0;
    #1;
    checkResetOutputs();
    expQ.delete();
    mX = 0;
    mY = 0;
    mScroll = 0;
    repeat (3) begin
      @(negedge clk_sys);
      checkOutput("noWriteInReset", 32'(bus.tram_we), 32'd0);
    end
    rst_sys = 1'b1;
    repeat (3) @(negedge clk_sys);
    checkState();
    applyStimulus(8'h5A, 4'hE, 4'h3);
    waitIdle();
    checkOutput("postResetAddr", 32'(lastAddr), 32'd0);
    checkState();

    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
